// File: rtl/fetch_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_ifu_pkg;

  localparam int          PC_W         = 64;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  // Fetch FSM: issue request, wait for response, hold for decode.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/fetch_ifu_if.sv
// Bundle of the fetch unit's redirect, instruction-memory and decode-side
// handshakes. The master modport is the fetch unit's view; the slave
// modport is the surrounding pipeline and memory.
interface fetch_ifu_if #(
  parameter int PC_W = 64
);

  // Redirect from execute.
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;

  // Instruction memory request / response.
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_inst;

  // Handoff to decode.
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_snpc;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_inst,
    input  out_ready,
    output imem_req_valid, imem_req_addr,
    output out_valid, out_pc, out_inst, out_snpc
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_inst,
    output out_ready,
    input  imem_req_valid, imem_req_addr,
    input  out_valid, out_pc, out_inst, out_snpc
  );

endinterface

// File: rtl/fetch_ifu.sv
// Instruction fetch unit: owns the PC, keeps a single request outstanding
// to instruction memory, registers the returned word and presents
// {pc, inst} to decode. Redirects from execute retarget the PC and squash
// whatever fetch is in flight.
module fetch_ifu
  import fetch_ifu_pkg::*;
#(
  parameter int            PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_ifu_if.master       bus
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  ifu_state_t      state_q,     state_d;
  logic [PC_W-1:0] pc_q,        pc_d;
  logic            kill_q,      kill_d;
  logic            out_valid_q, out_valid_d;
  logic [PC_W-1:0] out_pc_q,    out_pc_d;
  logic [31:0]     out_inst_q,  out_inst_d;

  logic            req_valid_c;
  logic [PC_W-1:0] redir_pc;
  logic [PC_W-1:0] pc_inc;

  // Instructions are word aligned; the low two target bits are discarded.
  assign redir_pc = {bus.redirect_pc[PC_W-1:2], 2'b00};
  assign pc_inc   = pc_q + PC_STEP;

  // State, PC, kill flag and decode-side output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= INST_NOP;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
    end
  end

  // Next-state logic: request, wait for the word, hold it for decode.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    req_valid_c = 1'b0;

    case (state_q)
      ST_REQ: begin
        req_valid_c = 1'b1;
        // An un-accepted request simply retargets; an accepted one that
        // coincides with a redirect is already stale and must be killed.
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
        end
        if (bus.imem_req_ready) begin
          state_d = ST_WAIT;
          kill_d  = bus.redirect_valid;
        end
      end

      ST_WAIT: begin
        if (bus.imem_resp_valid) begin
          if (kill_q || bus.redirect_valid) begin
            // Stale word: drop it and refetch from the (possibly new) PC.
            kill_d  = 1'b0;
            state_d = ST_REQ;
            if (bus.redirect_valid) begin
              pc_d = redir_pc;
            end
          end else begin
            out_inst_d  = bus.imem_resp_inst;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end else if (bus.redirect_valid) begin
          // The response still has to drain before the next request.
          pc_d   = redir_pc;
          kill_d = 1'b1;
        end
      end

      ST_HOLD: begin
        // Redirect wins over the handoff: the held word is on the wrong path.
        if (bus.redirect_valid) begin
          out_valid_d = 1'b0;
          pc_d        = redir_pc;
          state_d     = ST_REQ;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc_inc;
          state_d     = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // No request may escape while reset is asserted, even though the state
  // register already reads REQ.
  assign bus.imem_req_valid = req_valid_c & rst_n;
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_pc         = out_pc_q;
  assign bus.out_inst       = out_inst_q;
  assign bus.out_snpc       = out_pc_q + PC_STEP;

endmodule

// File: tb/tb_fetch_ifu.sv
// Bench for fetch_ifu: directed scenarios followed by a randomized run in
// which the bench plays instruction memory and tracks, at transaction
// level, which PC the next instruction handed to decode must carry.
module tb_fetch_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   vectors;
  int   misc;

  fetch_ifu_if #(.PC_W(64)) ifc ();

  fetch_ifu #(.PC_W(64), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents: an odd-multiplier hash so distinct addresses give
  // distinct words.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  initial begin
    logic [63:0] exp_pc;
    logic [63:0] tgt;
    logic [63:0] paddr;
    logic        pend;
    int          cnt;
    int          handoffs;
    logic        rv, ov, rdy, rdr, ordy;
    logic [63:0] ra, op, os;
    logic [31:0] oi;

    clk = 1'b0;
    rst_n = 1'b0;
    vectors = 0;
    misc = 0;
    ifc.redirect_valid  = 1'b0;
    ifc.redirect_pc     = '0;
    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_resp_inst  = '0;
    ifc.out_ready       = 1'b0;

    // ---------------- reset values
    #12;
    chk("rst_req_valid", 64'(ifc.imem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_out_pc", ifc.out_pc, 64'd0);
    chk("rst_out_inst", 64'(ifc.out_inst), 64'(NOP));
    chk("rst_req_addr", ifc.imem_req_addr, RST_PC);

    // ---------------- first fetch, 1-cycle memory
    rst_n = 1'b1;
    #1;
    chk("t1_req_valid", 64'(ifc.imem_req_valid), 64'd1);
    chk("t1_req_addr", ifc.imem_req_addr, RST_PC);
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready = 1'b0;
    chk("t1_wait_no_req", 64'(ifc.imem_req_valid), 64'd0);
    ifc.imem_resp_valid = 1'b1;
    ifc.imem_resp_inst  = 32'h0000_0297;
    tick();
    ifc.imem_resp_valid = 1'b0;
    chk("t1_out_valid", 64'(ifc.out_valid), 64'd1);
    chk("t1_out_pc", ifc.out_pc, 64'h8000_0000);
    chk("t1_out_inst", 64'(ifc.out_inst), 64'h0000_0297);
    chk("t1_out_snpc", ifc.out_snpc, 64'h8000_0004);

    // ---------------- decode back-pressure in HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 64'(ifc.out_valid), 64'd1);
      chk("t2_hold_pc", ifc.out_pc, 64'h8000_0000);
      chk("t2_hold_inst", 64'(ifc.out_inst), 64'h0000_0297);
      chk("t2_hold_no_req", 64'(ifc.imem_req_valid), 64'd0);
    end
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    chk("t2_out_dropped", 64'(ifc.out_valid), 64'd0);
    chk("t2_next_req", 64'(ifc.imem_req_valid), 64'd1);
    chk("t2_next_addr", ifc.imem_req_addr, 64'h8000_0004);
    tick();
    chk("t2_single_handoff", 64'(ifc.out_valid), 64'd0);

    // ---------------- redirect while waiting, stale response discarded
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'h8000_1006;
    tick();
    ifc.redirect_valid  = 1'b0;
    ifc.imem_resp_valid = 1'b1;
    ifc.imem_resp_inst  = 32'hDEAD_BEEF;
    tick();
    ifc.imem_resp_valid = 1'b0;
    chk("t3_discard_valid", 64'(ifc.out_valid), 64'd0);
    chk("t3_refetch_req", 64'(ifc.imem_req_valid), 64'd1);
    chk("t3_refetch_addr", ifc.imem_req_addr, 64'h8000_1004);

    // ---------------- redirect in HOLD beats out_ready
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b1;
    ifc.imem_resp_inst  = 32'h1111_1111;
    tick();
    ifc.imem_resp_valid = 1'b0;
    chk("t4_hold_pc", ifc.out_pc, 64'h8000_1004);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'h8000_0100;
    ifc.out_ready      = 1'b1;
    tick();
    ifc.redirect_valid = 1'b0;
    ifc.out_ready      = 1'b0;
    chk("t4_out_dropped", 64'(ifc.out_valid), 64'd0);
    chk("t4_next_addr", ifc.imem_req_addr, 64'h8000_0100);

    // ---------------- redirect in the accept cycle
    ifc.imem_req_ready = 1'b1;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'h8000_2000;
    tick();
    ifc.imem_req_ready  = 1'b0;
    ifc.redirect_valid  = 1'b0;
    chk("t5_wait_no_req", 64'(ifc.imem_req_valid), 64'd0);
    ifc.imem_resp_valid = 1'b1;
    ifc.imem_resp_inst  = 32'h0000_0BAD;
    tick();
    ifc.imem_resp_valid = 1'b0;
    chk("t5_killed_valid", 64'(ifc.out_valid), 64'd0);
    chk("t5_refetch_addr", ifc.imem_req_addr, 64'h8000_2000);
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b1;
    ifc.imem_resp_inst  = 32'h2222_2222;
    tick();
    ifc.imem_resp_valid = 1'b0;
    chk("t5_out_pc", ifc.out_pc, 64'h8000_2000);
    chk("t5_out_inst", 64'(ifc.out_inst), 64'h2222_2222);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;

    // ---------------- retarget an un-accepted request
    for (int i = 0; i < 3; i++) begin
      chk("t5b_stall_addr", ifc.imem_req_addr, 64'h8000_2004);
      tick();
    end
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'h8000_3000;
    tick();
    ifc.redirect_valid = 1'b0;
    chk("t5b_req_valid", 64'(ifc.imem_req_valid), 64'd1);
    chk("t5b_new_addr", ifc.imem_req_addr, 64'h8000_3000);
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b1;
    ifc.imem_resp_inst  = 32'h3333_3333;
    tick();
    ifc.imem_resp_valid = 1'b0;
    chk("t5b_out_pc", ifc.out_pc, 64'h8000_3000);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;

    // ---------------- PC wrap at the top of the address space
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    ifc.redirect_valid = 1'b0;
    chk("wrap_req_addr", ifc.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b1;
    ifc.imem_resp_inst  = 32'h4444_4444;
    tick();
    ifc.imem_resp_valid = 1'b0;
    chk("wrap_snpc", ifc.out_snpc, 64'd0);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    chk("wrap_next_addr", ifc.imem_req_addr, 64'd0);

    // ---------------- reset in the middle of WAIT, late response
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req_valid", 64'(ifc.imem_req_valid), 64'd0);
    chk("t6_rst_addr", ifc.imem_req_addr, RST_PC);
    tick();
    rst_n = 1'b1;
    ifc.imem_resp_valid = 1'b1;
    ifc.imem_resp_inst  = 32'h5555_5555;
    tick();
    ifc.imem_resp_valid = 1'b0;
    chk("t6_late_resp_valid", 64'(ifc.out_valid), 64'd0);
    chk("t6_req_valid", 64'(ifc.imem_req_valid), 64'd1);
    chk("t6_req_addr", ifc.imem_req_addr, RST_PC);
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b1;
    ifc.imem_resp_inst  = 32'h6666_6666;
    tick();
    ifc.imem_resp_valid = 1'b0;
    chk("t6_fresh_pc", ifc.out_pc, RST_PC);
    chk("t6_fresh_inst", 64'(ifc.out_inst), 64'h6666_6666);

    // ---------------- randomized run against a transaction-level model
    rst_n = 1'b0;
    ifc.out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_pc   = RST_PC;
    pend     = 1'b0;
    paddr    = '0;
    cnt      = 0;
    handoffs = 0;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rv = ifc.imem_req_valid;
      ra = ifc.imem_req_addr;
      ov = ifc.out_valid;
      op = ifc.out_pc;
      oi = ifc.out_inst;
      os = ifc.out_snpc;

      chk("rnd_one_outstanding", 64'(rv && (ov || pend)), 64'd0);

      rdy  = ($urandom_range(0, 3) != 0);
      rdr  = ($urandom_range(0, 15) == 0);
      ordy = ($urandom_range(0, 1) == 1);
      tgt  = 64'h8000_0000 | 64'($urandom_range(0, 32'hFFFF));

      ifc.imem_resp_valid = 1'b0;
      ifc.imem_resp_inst  = $urandom;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          ifc.imem_resp_valid = 1'b1;
          ifc.imem_resp_inst  = mem_word(paddr);
          pend = 1'b0;
        end
      end else begin
        // Stray responses outside a fetch must be ignored.
        ifc.imem_resp_valid = ($urandom_range(0, 7) == 0);
      end
      ifc.imem_req_ready = rdy;
      ifc.redirect_valid = rdr;
      ifc.redirect_pc    = tgt;
      ifc.out_ready      = ordy;

      if (rv && rdy) begin
        pend  = 1'b1;
        paddr = ra;
        cnt   = $urandom_range(1, 3);
      end
      if (ov && ordy && !rdr) begin
        chk("rnd_out_pc", op, exp_pc);
        chk("rnd_out_inst", 64'(oi), 64'(mem_word(op)));
        chk("rnd_out_snpc", os, op + 64'd4);
        exp_pc = exp_pc + 64'd4;
        handoffs++;
      end
      if (rdr) begin
        exp_pc = tgt & ~64'h3;
      end
    end

    @(negedge clk);
    ifc.redirect_valid  = 1'b0;
    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b0;
    ifc.out_ready       = 1'b0;
    chk("rnd_progress", 64'(handoffs > 20), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
